// File: rtl/digitron_capture.sv
// Captures a six-digit multiplexed 7-segment display (active-low CS, active-high segments) as hex.
// Define DIGITRON_CAPTURE_TIMEOUT_EN to build the optional no-activity watchdog.
module digitron_capture #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  Seg_In,
  input  logic [5:0]  CS_In,
  input  logic        Clear,
  output logic [23:0] Hex_SixNum_Out,
  output logic        Frame_Valid,
  output logic [5:0]  Digit_Mask,
  output logic        Locked,
  output logic        Err_Seg,
  output logic        Err_CS,
  output logic        Timeout
);

  if (STABLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("STABLE_CYC and TIMEOUT_CYC must be at least 1");
  end

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);
  localparam logic [CntW-1:0] CntAcc = CntW'(STABLE_CYC - 1);

  logic [13:0]     sync1_q, sync2_q;
  logic [1:0]      vld_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic [5:0]      acc_cs_q;
  logic [6:0]      acc_seg_q;

  logic [23:0] shadow_q, shadow_d, shadow_wr;
  logic [23:0] hex_q, hex_d;
  logic [5:0]  mask_q, mask_d, mask_wr;
  logic        fv_q, fv_d, locked_q, locked_d;
  logic        eseg_q, eseg_d, ecs_q, ecs_d;
  logic [5:0]  cs_sel;
  logic        cs_blank, cs_onehot, seg_ok;
  logic [3:0]  nib;

  // cnt_q == STABLE_CYC-1 means the synchronized sample has been seen STABLE_CYC times in a row;
  // vld_q keeps the reset contents of the synchronizer from being accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    acc_d = vld_q[1] && (cnt_q == CntAcc);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      vld_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      acc_cs_q  <= '0;
      acc_seg_q <= '0;
    end else begin
      sync1_q <= {CS_In, Seg_In};
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (acc_d) begin
        acc_cs_q  <= sync2_q[13:8];
        acc_seg_q <= sync2_q[6:0];
      end
    end
  end

  always_comb begin
    seg_ok = 1'b1;
    nib    = 4'h0;
    case (acc_seg_q)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  always_comb begin
    cs_sel    = ~acc_cs_q;
    cs_blank  = (acc_cs_q == 6'h3F);
    cs_onehot = !cs_blank && ((cs_sel & (cs_sel - 6'd1)) == 6'd0);
    mask_wr   = mask_q | cs_sel;
    shadow_wr = shadow_q;
    for (int k = 0; k < 6; k++) begin
      if (cs_sel[k]) begin
        shadow_wr[4*k +: 4] = nib;
      end
    end
  end

`ifdef DIGITRON_CAPTURE_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_hit;
  logic           to_q, to_d;

  always_comb begin
    wd_hit = !acc_q && (wd_q == WdW'(TIMEOUT_CYC - 1));
    wd_d   = wd_q;
    if (Clear || acc_q) begin
      wd_d = '0;
    end else if (wd_q != WdW'(TIMEOUT_CYC)) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign Timeout = to_q;
`else
  assign Timeout = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q;
    hex_d    = hex_q;
    fv_d     = 1'b0;
    locked_d = locked_q;
    eseg_d   = eseg_q;
    ecs_d    = ecs_q;
`ifdef DIGITRON_CAPTURE_TIMEOUT_EN
    to_d     = to_q;
`endif
    if (Clear) begin
      shadow_d = '0;
      mask_d   = '0;
      hex_d    = '0;
      locked_d = 1'b0;
      eseg_d   = 1'b0;
      ecs_d    = 1'b0;
`ifdef DIGITRON_CAPTURE_TIMEOUT_EN
      to_d     = 1'b0;
`endif
    end else begin
      if (acc_q && !cs_blank) begin
        if (!cs_onehot) begin
          ecs_d = 1'b1;
        end else if (!seg_ok) begin
          eseg_d = 1'b1;
        end else begin
          shadow_d = shadow_wr;
          if (mask_wr == 6'h3F) begin
            hex_d    = shadow_wr;
            fv_d     = 1'b1;
            locked_d = 1'b1;
            mask_d   = '0;
          end else begin
            mask_d = mask_wr;
          end
        end
      end
`ifdef DIGITRON_CAPTURE_TIMEOUT_EN
      if (wd_hit) begin
        to_d     = 1'b1;
        locked_d = 1'b0;
        mask_d   = '0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shadow_q <= '0;
      mask_q   <= '0;
      hex_q    <= '0;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      eseg_q   <= 1'b0;
      ecs_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      hex_q    <= hex_d;
      fv_q     <= fv_d;
      locked_q <= locked_d;
      eseg_q   <= eseg_d;
      ecs_q    <= ecs_d;
    end
  end

  assign Hex_SixNum_Out = hex_q;
  assign Frame_Valid    = fv_q;
  assign Digit_Mask     = mask_q;
  assign Locked         = locked_q;
  assign Err_Seg        = eseg_q;
  assign Err_CS         = ecs_q;

endmodule

// File: tb/tb_digitron_capture.sv
// Bench for digitron_capture: directed table, multi-cycle corner sequences and random holds
// checked every cycle against a run-length / accept-queue reference model.
module tb_digitron_capture;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TO     = 1000;
  localparam logic [6:0] SEG_LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  Seg_In = 8'h00;
  logic [5:0]  CS_In = 6'h3F;
  logic        Clear = 1'b0;
  logic [23:0] Hex_SixNum_Out;
  logic        Frame_Valid;
  logic [5:0]  Digit_Mask;
  logic        Locked, Err_Seg, Err_CS, Timeout;

  digitron_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TO)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .Seg_In         (Seg_In),
    .CS_In          (CS_In),
    .Clear          (Clear),
    .Hex_SixNum_Out (Hex_SixNum_Out),
    .Frame_Valid    (Frame_Valid),
    .Digit_Mask     (Digit_Mask),
    .Locked         (Locked),
    .Err_Seg        (Err_Seg),
    .Err_CS         (Err_CS),
    .Timeout        (Timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;

  always @(negedge CLK) if (RSTn && Frame_Valid === 1'b1) fv_cnt++;

  // Reference model: a sample held STABLE cycles in a row is accepted and takes effect 3 edges
  // after its STABLE-th sample (2 sync + 1 register).
  typedef struct { int due; logic [13:0] v; } pend_t;
  pend_t       pend[$];
  int          m_cyc = 0;
  int          m_run = 0;
  bit          m_has_prev = 0;
  logic [13:0] m_prev;
  logic [3:0]  m_nib [6];
  logic [5:0]  m_mask;
  logic [23:0] m_hex;
  logic        m_fv, m_locked, m_eseg, m_ecs;

  typedef struct {
    logic [5:0]  cs;
    logic [7:0]  seg;
    int          len;
    logic [23:0] hex;
    logic [5:0]  mask;
    logic        lock, eseg, ecs;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_nib[i] = 4'h0;
    m_mask = '0; m_hex = '0; m_locked = 0; m_eseg = 0; m_ecs = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_fv = 0; m_run = 0; m_has_prev = 0;
    pend.delete();
  endtask

  task automatic model_apply(input logic [13:0] v);
    logic [5:0] sel;
    int n, k;
    if (v[13:8] == 6'h3F) return;
    sel = ~v[13:8];
    if ($countones(sel) != 1) begin
      m_ecs = 1;
      return;
    end
    n = -1;
    for (int i = 0; i < 16; i++) if (SEG_LUT[i] == v[6:0]) n = i;
    if (n < 0) begin
      m_eseg = 1;
      return;
    end
    k = 0;
    for (int i = 0; i < 6; i++) if (sel[i]) k = i;
    m_nib[k] = n[3:0];
    m_mask[k] = 1'b1;
    if (m_mask == 6'h3F) begin
      for (int i = 0; i < 6; i++) m_hex[4*i +: 4] = m_nib[i];
      m_fv = 1; m_locked = 1; m_mask = '0;
    end
  endtask

  task automatic model_edge();
    logic [13:0] v;
    m_fv = 0;
    m_cyc++;
    if (Clear) begin
      model_clear();
      if (pend.size() > 0 && pend[0].due == m_cyc) void'(pend.pop_front());
    end else if (pend.size() > 0 && pend[0].due == m_cyc) begin
      v = pend[0].v;
      void'(pend.pop_front());
      model_apply(v);
    end
    v = {CS_In, Seg_In};
    if (!m_has_prev || v != m_prev) m_run = 1;
    else m_run++;
    m_prev = v;
    m_has_prev = 1;
    if (m_run == STABLE) pend.push_back('{m_cyc + 3, v});
  endtask

  task automatic compare_all();
    chk("hex", Hex_SixNum_Out, m_hex);
    chk("mask", Digit_Mask, m_mask);
    chk("frame_valid", Frame_Valid, m_fv);
    chk("locked", Locked, m_locked);
    chk("err_seg", Err_Seg, m_eseg);
    chk("err_cs", Err_CS, m_ecs);
`ifndef DIGITRON_CAPTURE_TIMEOUT_EN
    chk("timeout", Timeout, 1'b0);
`endif
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RSTn) model_edge();
    @(negedge CLK);
    if (RSTn) begin
      compare_all();
    end else begin
      chk("rst_hex", Hex_SixNum_Out, 24'h0);
      chk("rst_ctl", {Frame_Valid, Digit_Mask, Locked, Err_Seg, Err_CS, Timeout}, 11'h0);
    end
  endtask

  task automatic hold(input logic [5:0] cs, input logic [7:0] seg, input int n);
    CS_In = cs;
    Seg_In = seg;
    repeat (n) cycle();
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    cycle();
    Clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  initial begin
    int fv0;
    logic [7:0] d_seg [6];
    logic [5:0] cs;
    logic [7:0] seg;
    logic [31:0] rnd;
    bit seen;

    tbl[0]  = '{6'h3E, 8'h39, 20, 24'h000000, 6'h01, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{6'h3F, 8'h00, 20, 24'h000000, 6'h01, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{6'h3D, 8'h7C, 20, 24'h000000, 6'h03, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{6'h3B, 8'h00, 20, 24'h000000, 6'h03, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{6'h3B, 8'h77, 20, 24'h000000, 6'h07, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{6'h3C, 8'h00, 10, 24'h000000, 6'h07, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{6'h37, 8'h4F, 20, 24'h000000, 6'h0F, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{6'h2F, 8'h5B, 20, 24'h000000, 6'h1F, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{6'h1F, 8'h06, 20, 24'h123ABC, 6'h00, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{6'h3E, 8'h7F, 20, 24'h123ABC, 6'h01, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{6'h3F, 8'h80, 20, 24'h123ABC, 6'h01, 1'b1, 1'b1, 1'b1};

    model_reset();
    repeat (3) cycle();
    RSTn = 1'b1;
    hold(6'h3F, 8'h00, 10);

    for (int i = 0; i < 11; i++) begin
      hold(tbl[i].cs, tbl[i].seg, tbl[i].len);
      chk($sformatf("tbl%0d_hex", i), Hex_SixNum_Out, tbl[i].hex);
      chk($sformatf("tbl%0d_mask", i), Digit_Mask, tbl[i].mask);
      chk($sformatf("tbl%0d_locked", i), Locked, tbl[i].lock);
      chk($sformatf("tbl%0d_err_seg", i), Err_Seg, tbl[i].eseg);
      chk($sformatf("tbl%0d_err_cs", i), Err_CS, tbl[i].ecs);
    end

    pulse_clear();
    chk("clear_hex", Hex_SixNum_Out, 24'h0);
    chk("clear_flags", {Digit_Mask, Locked, Err_Seg, Err_CS}, 9'h0);

    // Stable edge to registered effect takes 2 + STABLE + 1 edges.
    CS_In = 6'h3E; Seg_In = 8'h06;
    repeat (STABLE + 2) cycle();
    chk("latency_before", Digit_Mask, 6'h00);
    cycle();
    chk("latency_at", Digit_Mask, 6'h01);
    repeat (5) cycle();

    // Clear lands on the very edge where the digit-1 accept would be written.
    CS_In = 6'h3D; Seg_In = 8'h06;
    repeat (STABLE + 2) cycle();
    pulse_clear();
    repeat (10) cycle();
    chk("clear_priority_mask", Digit_Mask, 6'h00);

    d_seg = '{8'h39, 8'h7C, 8'h77, 8'h4F, 8'h5B, 8'h06};
    fv0 = fv_cnt;
    for (int k = 0; k < 6; k++) hold(~(6'b1 << k), d_seg[k], 201);
    chk("frame123abc_hex", Hex_SixNum_Out, 24'h123ABC);
    chk("frame123abc_fv_count", fv_cnt - fv0, 1);
    chk("frame123abc_flags", {Locked, Err_Seg, Err_CS}, 3'b100);

    hold(6'h3E, 8'h3F, 20);
    hold(6'h3D, 8'h06, 20);
    hold(6'h3B, 8'h5B, 20);
    hold(6'h37, 8'h4F, 20);
    hold(6'h37, 8'h7F, 2);
    hold(6'h37, 8'h4F, 20);
    chk("glitch_err_seg", Err_Seg, 1'b0);
    hold(6'h2F, 8'h66, 20);
    hold(6'h1F, 8'h6D, 20);
    chk("glitch_hex", Hex_SixNum_Out, 24'h543210);

    // Reset after three digits; a fresh full frame is then required.
    hold(6'h3E, 8'h7D, 20);
    hold(6'h3D, 8'h7D, 20);
    hold(6'h3B, 8'h7D, 20);
    RSTn = 1'b0; CS_In = 6'h3F; Seg_In = 8'h00;
    #1;
    chk("rst_async_hex", Hex_SixNum_Out, 24'h0);
    chk("rst_async_mask", Digit_Mask, 6'h0);
    repeat (4) cycle();
    model_reset();
    RSTn = 1'b1;
    hold(6'h3F, 8'h00, 10);
    fv0 = fv_cnt;
    for (int k = 0; k < 5; k++) hold(~(6'b1 << k), 8'h71, 20);
    chk("rst_frame_no_early_fv", fv_cnt - fv0, 0);
    hold(6'h1F, 8'h71, 20);
    chk("rst_frame_hex", Hex_SixNum_Out, 24'hFFFFFF);
    chk("rst_frame_fv_count", fv_cnt - fv0, 1);

    for (int it = 0; it < 300; it++) begin
      rnd = $urandom;
      if (rnd[6:0] < 7'd90) cs = ~(6'b1 << $urandom_range(0, 5));
      else if (rnd[6:0] < 7'd110) cs = 6'h3F;
      else cs = rnd[28:23];
      rnd = $urandom;
      if (rnd[3:0] < 4'd13) seg = {rnd[31], SEG_LUT[rnd[11:8]]};
      else seg = rnd[23:16];
      hold(cs, seg, $urandom_range(1, 12));
      if ($urandom_range(0, 29) == 0) pulse_clear();
    end

`ifdef DIGITRON_CAPTURE_TIMEOUT_EN
    pulse_clear();
    for (int k = 0; k < 5; k++) hold(~(6'b1 << k), 8'h06, 20);
    CS_In = 6'h1F; Seg_In = 8'h06;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (Frame_Valid) seen = 1;
    end
    chk("wd_frame_seen", seen, 1'b1);
    repeat (TO - 1) @(negedge CLK);
    chk("wd_before_timeout", {Timeout, Locked}, 2'b01);
    @(negedge CLK);
    chk("wd_timeout", {Timeout, Locked}, 2'b10);
    chk("wd_hex_retained", Hex_SixNum_Out, 24'h111111);
    chk("wd_mask_cleared", Digit_Mask, 6'h00);
`else
    seen = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digitron_capture.md
DIGITRON_CAPTURE -- requirements
Module: digitron_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4: number of consecutive cycles a synchronized {CS,segment} sample must stay unchanged before it is accepted.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1_000_000: watchdog limit in cycles, used only when the Configuration macro is defined.
REQ-003 The block SHALL have port CLK, input, 1 bit: system clock, all logic on the rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port Seg_In, input, 8 bits: active-high segment lines, bit0=a .. bit6=g, bit7=DP (bit7 ignored).
REQ-006 The block SHALL have port CS_In, input, 6 bits: active-low digit select, bit0 = least-significant digit.
REQ-007 The block SHALL have port Clear, input, 1 bit: synchronous clear of capture state.
REQ-008 The block SHALL have port Hex_SixNum_Out, output, 24 bits: last complete captured value, digit k in bits [4k+3:4k].
REQ-009 The block SHALL have port Frame_Valid, output, 1 bit: one-cycle pulse when Hex_SixNum_Out is updated.
REQ-010 The block SHALL have port Digit_Mask, output, 6 bits: digits captured in the current partial frame.
REQ-011 The block SHALL have port Locked, output, 1 bit: set once at least one frame has completed.
REQ-012 The block SHALL have port Err_Seg, output, 1 bit: sticky flag for an undecodable segment pattern.
REQ-013 The block SHALL have port Err_CS, output, 1 bit: sticky flag for an illegal CS pattern.
REQ-014 The block SHALL have port Timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-015 Seg_In and CS_In SHALL pass through a two-flop synchronizer before any use.
REQ-016 A stability counter SHALL reset to 0 on any change of the synchronized 14-bit sample and SHALL otherwise saturate at STABLE_CYC.
REQ-017 An accept event SHALL fire exactly once per stable period, in the cycle the counter reaches STABLE_CYC; pulses shorter than STABLE_CYC cycles SHALL be ignored.
REQ-018 On accept, CS=6'b111111 SHALL be treated as blanking: no write, no error.
REQ-019 On accept, any CS pattern other than exactly one zero bit, excluding the blanking case, SHALL set Err_CS and write nothing.
REQ-020 On accept with a legal CS, Seg_In[6:0] SHALL decode as 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71 (hex).
REQ-021 A non-matching segment pattern SHALL set Err_Seg and SHALL leave the shadow register and Digit_Mask unchanged.
REQ-022 A decoded nibble SHALL be written into shadow slot k and SHALL set Digit_Mask[k]; re-capturing a digit already in the mask SHALL overwrite it without error.
REQ-023 When the mask including the current write equals 6'b111111, the next edge SHALL copy the shadow register (with the current nibble) to Hex_SixNum_Out, pulse Frame_Valid, set Locked and clear Digit_Mask.
REQ-024 Latency from a stable CS/segment edge to the registered effect SHALL be 2 + STABLE_CYC + 1 cycles.
REQ-025 Clear SHALL zero Digit_Mask, shadow, Hex_SixNum_Out, Locked, Err_Seg, Err_CS and Timeout, and SHALL take priority over an accept in the same cycle.
REQ-026 Err_Seg and Err_CS SHALL remain set until Clear or reset.

Reset
REQ-027 While RSTn=0, all outputs, the synchronizers, the stability counter, the shadow register and the watchdog SHALL be 0.
REQ-028 After reset is released mid-frame, a full new six-digit frame SHALL be required before Frame_Valid asserts.

Configuration
REQ-029 With DIGITRON_CAPTURE_TIMEOUT_EN defined, a watchdog SHALL count cycles since the last accept event.
REQ-030 When that count reaches TIMEOUT_CYC, the watchdog SHALL set Timeout, clear Locked and clear Digit_Mask; Hex_SixNum_Out SHALL be retained.
REQ-031 Without DIGITRON_CAPTURE_TIMEOUT_EN, no watchdog logic SHALL exist and Timeout SHALL be tied to 0.

Verification
REQ-032 Six digits of 0x123ABC, each held 201 cycles in CS order bit0..bit5 -> Hex_SixNum_Out=0x123ABC, exactly one Frame_Valid pulse, Locked=1, no errors.
REQ-033 Seg_In glitching to 0x7F for 2 cycles while digit 3 shows 0x4F, STABLE_CYC=4 -> glitch ignored, digit 3 captured as 3, Err_Seg=0.
REQ-034 Digit 2 with Seg_In=0x00 -> Err_Seg=1, Digit_Mask[2]=0, no Frame_Valid until a valid digit 2 arrives.
REQ-035 CS_In=6'b111100 held 10 cycles -> Err_CS=1, Digit_Mask unchanged; CS_In=6'b111111 -> no error.
REQ-036 RSTn low after three digits, then one full frame of 0xFFFFFF -> all outputs 0 during reset, then one Frame_Valid with Hex_SixNum_Out=0xFFFFFF.
REQ-037 With the macro defined and TIMEOUT_CYC=1000, inputs frozen after a frame -> Timeout=1 and Locked=0 at cycle 1000, Hex_SixNum_Out retained.
